tx_credit_tracker: RTL and testbench
====================================

Name: tx_credit_tracker

Overview:
- Per-VC transmit credit counter in the TLK. Sits directly downstream of the RLK block decoder's returned-credit outputs (credits, hi_credits, credits_valid).
- Adds credits returned by the partner and subtracts credits consumed by the TLK arbiter for each data word it sends.
- Presents a registered per-VC "may send" vector to the arbiter.
- Flags protocol violations: credit underflow and counter overflow.

Parameters:
- NUM_VCS, 13, number of virtual channels tracked (1..16).
- CNT_W, 8, width of each per-VC credit counter.
- INIT_CREDITS, 32, value loaded into every counter on reset and on link_init.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- link_init  in  1  one-cycle pulse from the TLK state machine at link (re)synchronisation; reloads every counter.
- credits  in  8  returned-credit bitmap from the block decoder.
- hi_credits  in  1  selects the bitmap half: 0 = VCs 0..7, 1 = VCs 8..15.
- credits_valid  in  1  credits/hi_credits are valid this cycle.
- consume_valid  in  1  arbiter emitted data words this cycle.
- consume_mask  in  NUM_VCS  one bit per VC; each set bit consumes one credit.
- credit_avail  out  NUM_VCS  registered; bit v = (count[v] != 0).
- credit_count  out  NUM_VCS*CNT_W  registered counters; VC v occupies bits [v*CNT_W +: CNT_W].
- underflow_err  out  1  sticky; set when a consume hits a zero counter.
- overflow_err  out  1  sticky; set when a return hits an all-ones counter.

Behaviour:
- Reset (rst=1, sampled on the clk edge):
  - every counter = INIT_CREDITS;
  - credit_avail = all ones if INIT_CREDITS != 0, else all zeros;
  - underflow_err = 0, overflow_err = 0.
- link_init=1 (not in reset): same as reset, including clearing both error flags. All other inputs are ignored that cycle, and link_init has priority over any return or consume arriving in the same cycle.
- Return decode, per VC v, when credits_valid=1:
  - ret[v] = credits[v] if hi_credits=0 and v<8;
  - ret[v] = credits[v-8] if hi_credits=1 and v>=8;
  - otherwise ret[v] = 0.
  - Bitmap bits that map to v >= NUM_VCS are ignored silently.
- Consume: con[v] = consume_valid & consume_mask[v].
- Per-VC update each cycle (no reset, no link_init):
  - ret=1, con=0: count+1. If count == 2^CNT_W-1, hold the count and set overflow_err.
  - ret=0, con=1: count-1. If count == 0, hold 0 and set underflow_err.
  - ret=1, con=1: count unchanged. No error, even at 0 or at full: the return is treated as covering the consume.
  - Neither: hold.
- All VCs update independently in the same cycle. No arithmetic wraps in either direction.
- Latency:
  - An input in cycle N is visible on credit_count, credit_avail and the error flags in cycle N+1.
  - credit_avail is derived from the next-state counter value, so it never lags credit_count.
- The arbiter must only consume VCs whose credit_avail is 1. Underflow_err exists to catch a violation of that rule; the block does no flow control itself.
- credits_valid is only asserted for CRC-good data blocks, so no CRC qualification is done here.
- Error flags clear only on rst or link_init.
- A reset asserted mid-operation discards any in-flight update.

Test Plan:
- Reset, then idle 5 cycles -> all counts = 32, credit_avail = 13'h1FFF, both errors 0.
- credits=8'h05, hi=0, valid for 1 cycle -> next cycle VC0 = 33, VC2 = 33, all others 32.
- credits=8'hFF, hi=1, valid -> VCs 8..12 = 33; VCs 13..15 ignored; VCs 0..7 = 32; overflow_err = 0.
- consume_mask = VC3, consume_valid for 32 cycles -> VC3 reaches 0 and credit_avail[3] = 0. A 33rd consume -> VC3 stays 0 and underflow_err = 1.
- VC3 at 0, with a return credits=8'h08 (hi=0) and a VC3 consume in the same cycle -> VC3 stays 0 and underflow_err is not set.
- Preload VC1 to 255 via 223 returns, then 1 more return -> VC1 holds 255, overflow_err = 1. Pulse link_init together with a return -> all counts = 32, errors cleared.

Source files
------------

// File: rtl/tx_credit_tracker.sv
// tx_credit_tracker: per-VC transmit credit counters with registered may-send vector and sticky error flags
module tx_credit_tracker #(
  parameter int NUM_VCS      = 13,
  parameter int CNT_W        = 8,
  parameter int INIT_CREDITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     link_init,
  input  logic [7:0]               credits,
  input  logic                     hi_credits,
  input  logic                     credits_valid,
  input  logic                     consume_valid,
  input  logic [NUM_VCS-1:0]       consume_mask,
  output logic [NUM_VCS-1:0]       credit_avail,
  output logic [NUM_VCS*CNT_W-1:0] credit_count,
  output logic                     underflow_err,
  output logic                     overflow_err
);
  logic [NUM_VCS-1:0] unf, ovf;
  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    logic ret, con, full, empty;
    logic [CNT_W-1:0] cnt, nxt;
    if (v < 8) begin : g_lo
      assign ret = credits_valid & ~hi_credits & credits[v];
    end else begin : g_hi
      assign ret = credits_valid & hi_credits & credits[v-8];
    end
    assign con = consume_valid & consume_mask[v];
    assign full = &cnt;
    assign empty = ~|cnt;
    // a simultaneous return covers the consume, so neither error can fire
    assign ovf[v] = ret & ~con & full;
    assign unf[v] = con & ~ret & empty;
    always_comb nxt = (ret & ~con & ~full) ? cnt + 1'b1 : (con & ~ret & ~empty) ? cnt - 1'b1 : cnt;
    always_ff @(posedge clk) begin
      if (rst || link_init) begin
        cnt <= CNT_W'(INIT_CREDITS);
        credit_avail[v] <= (INIT_CREDITS != 0);
      end else begin
        cnt <= nxt;
        credit_avail[v] <= |nxt;
      end
    end
    assign credit_count[v*CNT_W +: CNT_W] = cnt;
  end
  always_ff @(posedge clk) begin
    if (rst || link_init) begin
      underflow_err <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      underflow_err <= underflow_err | (|unf);
      overflow_err <= overflow_err | (|ovf);
    end
  end
endmodule

// File: tb/tb_tx_credit_tracker.sv
// tb_tx_credit_tracker: directed + random scoreboard bench for tx_credit_tracker
module tb_tx_credit_tracker;
  localparam int N = 13;
  localparam int W = 8;
  logic clk = 0, rst = 0, link_init = 0, hi_credits = 0, credits_valid = 0, consume_valid = 0;
  logic [7:0] credits = 0;
  logic [N-1:0] consume_mask = 0;
  logic [N-1:0] credit_avail;
  logic [N*W-1:0] credit_count;
  logic underflow_err, overflow_err;
  int checks = 0, failures = 0;
  int m[N];
  logic mu = 0, mo = 0;
  typedef struct {
    logic [N*W-1:0] cnt;
    logic [N-1:0] av;
    logic u, o;
  } exp_t;
  exp_t q[$];

  tx_credit_tracker dut (
    .clk(clk), .rst(rst), .link_init(link_init), .credits(credits), .hi_credits(hi_credits),
    .credits_valid(credits_valid), .consume_valid(consume_valid), .consume_mask(consume_mask),
    .credit_avail(credit_avail), .credit_count(credit_count),
    .underflow_err(underflow_err), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N*W-1:0] a, input logic [N*W-1:0] e);
    checks++;
    assert (a === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, a, e);
    end
  endtask

  task automatic step(input logic r, input logic li, input logic cv, input logic hi,
                      input logic [7:0] cr, input logic cnv, input logic [N-1:0] mask);
    exp_t e;
    rst = r; link_init = li; credits_valid = cv; hi_credits = hi; credits = cr;
    consume_valid = cnv; consume_mask = mask;
    if (r || li) begin
      for (int v = 0; v < N; v++) m[v] = 32;
      mu = 0; mo = 0;
    end else begin
      for (int v = 0; v < N; v++) begin
        bit rb, cb;
        rb = cv && ((v < 8) ? (!hi && cr[v % 8]) : (hi && cr[v % 8]));
        cb = cnv && mask[v];
        if (rb && !cb) begin
          if (m[v] == 255) mo = 1; else m[v]++;
        end else if (cb && !rb) begin
          if (m[v] == 0) mu = 1; else m[v]--;
        end
      end
    end
    for (int v = 0; v < N; v++) begin
      e.cnt[v*W +: W] = W'(m[v]);
      e.av[v] = (m[v] != 0);
    end
    e.u = mu; e.o = mo;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("credit_count", credit_count, e.cnt);
    chk("credit_avail", {{(N*W-N){1'b0}}, credit_avail}, {{(N*W-N){1'b0}}, e.av});
    chk("underflow_err", {{(N*W-1){1'b0}}, underflow_err}, {{(N*W-1){1'b0}}, e.u});
    chk("overflow_err", {{(N*W-1){1'b0}}, overflow_err}, {{(N*W-1){1'b0}}, e.o});
  endtask

  initial begin
    step(1, 0, 0, 0, 8'h00, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 8'h00, 0, '0);
    chk("reset_avail_all", {{(N*W-N){1'b0}}, credit_avail}, {{(N*W-N){1'b0}}, 13'h1FFF});
    step(0, 0, 1, 0, 8'h05, 0, '0);
    chk("vc0_33", {96'd0, credit_count[0 +: 8]}, {96'd0, 8'd33});
    chk("vc2_33", {96'd0, credit_count[16 +: 8]}, {96'd0, 8'd33});
    step(0, 0, 1, 1, 8'hFF, 0, '0);
    chk("vc12_33", {96'd0, credit_count[96 +: 8]}, {96'd0, 8'd33});
    chk("vc7_32", {96'd0, credit_count[56 +: 8]}, {96'd0, 8'd32});
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 8'h00, 1, 13'h0008);
    chk("vc3_zero_avail", {103'd0, credit_avail[3]}, {103'd0, 1'b0});
    step(0, 0, 1, 0, 8'h08, 1, 13'h0008);
    chk("vc3_cover_no_unf", {103'd0, underflow_err}, {103'd0, 1'b0});
    step(0, 0, 0, 0, 8'h00, 1, 13'h0008);
    chk("vc3_underflow", {103'd0, underflow_err}, {103'd0, 1'b1});
    for (int i = 0; i < 223; i++) step(0, 0, 1, 0, 8'h02, 0, '0);
    chk("vc1_255", {96'd0, credit_count[8 +: 8]}, {96'd0, 8'd255});
    step(0, 0, 1, 0, 8'h02, 0, '0);
    chk("vc1_overflow", {103'd0, overflow_err}, {103'd0, 1'b1});
    step(0, 1, 1, 0, 8'h02, 1, 13'h1FFF);
    for (int i = 0; i < 60; i++)
      step(0, 0, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), N'($urandom));
    step(1, 0, 1, 0, 8'hFF, 1, 13'h1FFF);
    step(0, 0, 0, 0, 8'h00, 0, '0);
    chk("queue_drained", {96'd0, 8'(q.size())}, 104'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
